// File: rtl/tetris_link_receiver.sv
// Receive side of the two-player link: deserialises the four-lane opponent state
// frame and the single-lane handshake frame, then drives pulses, flags and latched state.
`timescale 1ns/1ps
module tetris_link_receiver #(
   parameter int GBG_BITS          = 4,
   parameter int TILE_BITS         = 4,
   parameter int NEXT_PIECES_COUNT = 6,
   parameter int PLAYFIELD_ROWS    = 20,
   parameter int PLAYFIELD_COLS    = 10
) (
   input  logic                                                      clk,
   input  logic                                                      rst,
   input  logic                                                      game_active,
   input  logic                                                      serial_in_h,
   input  logic                                                      serial_in_0,
   input  logic                                                      serial_in_1,
   input  logic                                                      serial_in_2,
   input  logic                                                      serial_in_3,
   output logic                                                      send_ready_ACK,
   output logic                                                      ack_seqNum_out,
   output logic                                                      ack_received,
   output logic                                                      ack_seqNum,
   output logic                                                      update_opponent_data,
   output logic [GBG_BITS-1:0]                                       opponent_garbage,
   output logic [TILE_BITS-1:0]                                      opponent_hold,
   output logic [NEXT_PIECES_COUNT-1:0][TILE_BITS-1:0]               opponent_piece_queue,
   output logic [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0][TILE_BITS-1:0] opponent_playfield,
   output logic                                                      opponent_ready,
   output logic                                                      opponent_lost,
   output logic                                                      receive_done,
   output logic                                                      receive_done_h,
   output logic [3:0]                                                packets_received_cnt,
   output logic [3:0]                                                acks_received_cnt
);

   localparam int PKT_BITS   = 1 + GBG_BITS + TILE_BITS * (1 + NEXT_PIECES_COUNT + PLAYFIELD_ROWS * PLAYFIELD_COLS);
   localparam int LANE_BITS  = (PKT_BITS + 3) / 4;
   localparam int FRAME_BITS = 4 * LANE_BITS;
   localparam int CNT_W      = $clog2(LANE_BITS + 1);
   localparam int HOLD_MSB   = PKT_BITS - 2 - GBG_BITS;
   localparam int QUEUE_MSB  = HOLD_MSB - TILE_BITS;
   localparam int FIELD_MSB  = QUEUE_MSB - NEXT_PIECES_COUNT * TILE_BITS;

   localparam logic [1:0] PID_ACK   = 2'b00;
   localparam logic [1:0] PID_READY = 2'b01;
   localparam logic [1:0] PID_LOST  = 2'b10;

   typedef enum logic [1:0] {D_IDLE, D_SHIFT, D_PARITY} d_state_t;
   typedef enum logic       {H_IDLE, H_SHIFT}           h_state_t;

   // Even parity: payload plus parity bit must carry an even number of ones.
   function automatic logic parity_ok(input logic [LANE_BITS-1:0] payload, input logic par_bit);
      return ~(^{payload, par_bit});
   endfunction

   d_state_t                         d_state, d_state_nxt;
   logic [CNT_W-1:0]                 d_cnt, d_cnt_nxt;
   logic                             start_ok, start_ok_nxt;
   logic [3:0]                       lanes;
   logic [3:0][LANE_BITS-1:0]        lane_sr;
   logic [PKT_BITS-1:0]              payload;
   logic                             frame_ok;
   logic                             d_done;
   logic                             d_accept;
   logic                             d_new;

   logic                             pkt_seq;
   logic [GBG_BITS-1:0]              pkt_gbg;
   logic [TILE_BITS-1:0]             pkt_hold;
   logic [NEXT_PIECES_COUNT-1:0][TILE_BITS-1:0]                    pkt_queue;
   logic [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0][TILE_BITS-1:0]   pkt_field;
   logic                             last_seq;

   h_state_t                         h_state, h_state_nxt;
   logic [2:0]                       h_cnt, h_cnt_nxt;
   logic [4:0]                       h_sr;
   logic [5:0]                       h_word;
   logic                             h_valid;
   logic [1:0]                       h_pid;

   assign lanes = {serial_in_3, serial_in_2, serial_in_1, serial_in_0};

   // Data frame sequencing: start bit, LANE_BITS payload bits, parity bit.
   always_comb begin
      d_state_nxt  = d_state;
      d_cnt_nxt    = d_cnt;
      start_ok_nxt = start_ok;
      case (d_state)
         D_IDLE: begin
            if (serial_in_0) begin
               d_state_nxt  = D_SHIFT;
               d_cnt_nxt    = '0;
               start_ok_nxt = &lanes;
            end
         end
         D_SHIFT: begin
            d_cnt_nxt = d_cnt + 1'b1;
            if (d_cnt == CNT_W'(LANE_BITS - 1)) d_state_nxt = D_PARITY;
         end
         D_PARITY: d_state_nxt = D_IDLE;
         default:  d_state_nxt = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_state  <= D_IDLE;
         d_cnt    <= '0;
         start_ok <= 1'b0;
      end else begin
         d_state  <= d_state_nxt;
         d_cnt    <= d_cnt_nxt;
         start_ok <= start_ok_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (d_state == D_SHIFT)
         for (int i = 0; i < 4; i++) lane_sr[i] <= {lane_sr[i][LANE_BITS-2:0], lanes[i]};
   end

   // Lane 0 carries the most significant slice; the LSB zero padding is dropped.
   assign payload = PKT_BITS'({lane_sr[0], lane_sr[1], lane_sr[2], lane_sr[3]} >> (FRAME_BITS - PKT_BITS));

   always_comb begin
      frame_ok = start_ok;
      for (int i = 0; i < 4; i++) frame_ok = frame_ok & parity_ok(lane_sr[i], lanes[i]);
   end

   assign pkt_seq  = payload[PKT_BITS-1];
   assign pkt_gbg  = payload[PKT_BITS-2 -: GBG_BITS];
   assign pkt_hold = payload[HOLD_MSB -: TILE_BITS];

   always_comb begin
      pkt_queue = '0;
      pkt_field = '0;
      for (int k = 0; k < NEXT_PIECES_COUNT; k++)
         pkt_queue[k] = payload[QUEUE_MSB - k * TILE_BITS -: TILE_BITS];
      for (int r = 0; r < PLAYFIELD_ROWS; r++)
         for (int c = 0; c < PLAYFIELD_COLS; c++)
            pkt_field[r][c] = payload[FIELD_MSB - (r * PLAYFIELD_COLS + c) * TILE_BITS -: TILE_BITS];
   end

   assign d_done   = (d_state == D_PARITY) && frame_ok;
   assign d_accept = d_done && game_active;
   assign d_new    = d_accept && (pkt_seq != last_seq);

   // Handshake frame: start bit then {seq, seq_n, pid[1:0], pid_n[1:0]}.
   always_comb begin
      h_state_nxt = h_state;
      h_cnt_nxt   = h_cnt;
      case (h_state)
         H_IDLE: begin
            if (serial_in_h) begin
               h_state_nxt = H_SHIFT;
               h_cnt_nxt   = '0;
            end
         end
         H_SHIFT: begin
            h_cnt_nxt = h_cnt + 1'b1;
            if (h_cnt == 3'd5) h_state_nxt = H_IDLE;
         end
         default: h_state_nxt = H_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_state <= H_IDLE;
         h_cnt   <= '0;
      end else begin
         h_state <= h_state_nxt;
         h_cnt   <= h_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (h_state == H_SHIFT) h_sr <= {h_sr[3:0], serial_in_h};
   end

   assign h_word  = {h_sr, serial_in_h};
   assign h_pid   = h_word[3:2];
   assign h_valid = (h_state == H_SHIFT) && (h_cnt == 3'd5) &&
                    (h_word[4] == ~h_word[5]) && (h_word[1:0] == ~h_word[3:2]);

   // Registered outputs: one-cycle pulses, counters, sticky flags and latched opponent state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         send_ready_ACK       <= 1'b0;
         ack_seqNum_out       <= 1'b0;
         ack_received         <= 1'b0;
         ack_seqNum           <= 1'b0;
         update_opponent_data <= 1'b0;
         opponent_garbage     <= '0;
         opponent_hold        <= '0;
         opponent_piece_queue <= '0;
         opponent_playfield   <= '0;
         opponent_ready       <= 1'b0;
         opponent_lost        <= 1'b0;
         receive_done         <= 1'b0;
         receive_done_h       <= 1'b0;
         packets_received_cnt <= '0;
         acks_received_cnt    <= '0;
         last_seq             <= 1'b1;
      end else begin
         receive_done         <= d_done;
         update_opponent_data <= d_new;
         receive_done_h       <= h_valid;
         ack_received         <= h_valid && (h_pid == PID_ACK);
         send_ready_ACK       <= d_accept || (h_valid && (h_pid == PID_READY));

         if (d_accept)
            ack_seqNum_out <= pkt_seq;
         else if (h_valid && (h_pid == PID_READY))
            ack_seqNum_out <= h_word[5];

         if (d_done) packets_received_cnt <= packets_received_cnt + 4'd1;

         if (d_new) begin
            opponent_garbage     <= pkt_gbg;
            opponent_hold        <= pkt_hold;
            opponent_piece_queue <= pkt_queue;
            opponent_playfield   <= pkt_field;
            last_seq             <= pkt_seq;
         end

         if (h_valid) begin
            case (h_pid)
               PID_ACK: begin
                  ack_seqNum        <= h_word[5];
                  acks_received_cnt <= acks_received_cnt + 4'd1;
               end
               PID_READY: opponent_ready <= 1'b1;
               PID_LOST:  opponent_lost  <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tetris_link_receiver.sv
// Bench for tetris_link_receiver: directed and randomized frames checked against a
// packet-level reference model.
`timescale 1ns/1ps
module tb_tetris_link_receiver;

   localparam int G = 4;
   localparam int T = 4;
   localparam int N = 6;
   localparam int R = 20;
   localparam int C = 10;
   localparam int P = 1 + G + T * (1 + N + R * C);
   localparam int L = (P + 3) / 4;

   logic clk = 1'b0;
   logic rst, game_active, serial_in_h, serial_in_0, serial_in_1, serial_in_2, serial_in_3;
   logic send_ready_ACK, ack_seqNum_out, ack_received, ack_seqNum, update_opponent_data;
   logic [G-1:0] opponent_garbage;
   logic [T-1:0] opponent_hold;
   logic [N-1:0][T-1:0] opponent_piece_queue;
   logic [R-1:0][C-1:0][T-1:0] opponent_playfield;
   logic opponent_ready, opponent_lost, receive_done, receive_done_h;
   logic [3:0] packets_received_cnt, acks_received_cnt;

   tetris_link_receiver #(
      .GBG_BITS(G), .TILE_BITS(T), .NEXT_PIECES_COUNT(N), .PLAYFIELD_ROWS(R), .PLAYFIELD_COLS(C)
   ) dut (
      .clk(clk), .rst(rst), .game_active(game_active), .serial_in_h(serial_in_h),
      .serial_in_0(serial_in_0), .serial_in_1(serial_in_1), .serial_in_2(serial_in_2),
      .serial_in_3(serial_in_3), .send_ready_ACK(send_ready_ACK), .ack_seqNum_out(ack_seqNum_out),
      .ack_received(ack_received), .ack_seqNum(ack_seqNum),
      .update_opponent_data(update_opponent_data), .opponent_garbage(opponent_garbage),
      .opponent_hold(opponent_hold), .opponent_piece_queue(opponent_piece_queue),
      .opponent_playfield(opponent_playfield), .opponent_ready(opponent_ready),
      .opponent_lost(opponent_lost), .receive_done(receive_done), .receive_done_h(receive_done_h),
      .packets_received_cnt(packets_received_cnt), .acks_received_cnt(acks_received_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Packet about to be transmitted
   logic         pk_seq;
   logic [G-1:0] pk_gbg;
   logic [T-1:0] pk_hold;
   logic [T-1:0] pk_q [N];
   logic [T-1:0] pk_pf [R][C];

   // Reference model state and expected pulses
   logic         m_last_seq, m_ready, m_lost, m_ack_seq, m_ack_out;
   logic [G-1:0] m_gbg;
   logic [T-1:0] m_hold;
   logic [T-1:0] m_q [N];
   logic [T-1:0] m_pf [R][C];
   int           m_pkt_cnt, m_ack_cnt;
   logic         e_rd, e_upd, e_sra, e_rdh, e_ackr;
   bit           pending = 1'b0;

   logic [4*L-1:0] pkt;
   int             pos;

   task automatic chk(input string tag, input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
      end
   endtask

   task automatic clear_pulses();
      e_rd = 0; e_upd = 0; e_sra = 0; e_rdh = 0; e_ackr = 0;
   endtask

   task automatic model_reset();
      clear_pulses();
      m_last_seq = 1'b1; m_ready = 0; m_lost = 0; m_ack_seq = 0; m_ack_out = 0;
      m_gbg = '0; m_hold = '0; m_pkt_cnt = 0; m_ack_cnt = 0;
      for (int k = 0; k < N; k++) m_q[k] = '0;
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) m_pf[r][c] = '0;
   endtask

   task automatic check_pulses_low(input string tag);
      chk(tag, "rd_low", receive_done, 0);
      chk(tag, "upd_low", update_opponent_data, 0);
      chk(tag, "sra_low", send_ready_ACK, 0);
      chk(tag, "rdh_low", receive_done_h, 0);
      chk(tag, "ackr_low", ack_received, 0);
   endtask

   task automatic check_state(input string tag);
      int nbad;
      chk(tag, "receive_done", receive_done, e_rd);
      chk(tag, "update", update_opponent_data, e_upd);
      chk(tag, "send_ready_ACK", send_ready_ACK, e_sra);
      chk(tag, "receive_done_h", receive_done_h, e_rdh);
      chk(tag, "ack_received", ack_received, e_ackr);
      chk(tag, "ack_seqNum_out", ack_seqNum_out, m_ack_out);
      chk(tag, "ack_seqNum", ack_seqNum, m_ack_seq);
      chk(tag, "pkt_cnt", packets_received_cnt, 64'(m_pkt_cnt));
      chk(tag, "ack_cnt", acks_received_cnt, 64'(m_ack_cnt));
      chk(tag, "ready", opponent_ready, m_ready);
      chk(tag, "lost", opponent_lost, m_lost);
      chk(tag, "garbage", opponent_garbage, m_gbg);
      chk(tag, "hold", opponent_hold, m_hold);
      nbad = 0;
      for (int k = 0; k < N; k++) if (opponent_piece_queue[k] !== m_q[k]) nbad++;
      chk(tag, "queue_bad_entries", 64'(nbad), 0);
      nbad = 0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) if (opponent_playfield[r][c] !== m_pf[r][c]) nbad++;
      chk(tag, "playfield_bad_tiles", 64'(nbad), 0);
   endtask

   task automatic hs_model(input logic seq, input logic [1:0] pid);
      e_rdh = 1;
      case (pid)
         2'b00: begin e_ackr = 1; m_ack_seq = seq; m_ack_cnt = (m_ack_cnt + 1) % 16; end
         2'b01: begin m_ready = 1; e_sra = 1; m_ack_out = seq; end
         2'b10: m_lost = 1;
         default: ;
      endcase
   endtask

   task automatic fill_pkt(input logic seq, input logic [G-1:0] gbg, input bit rnd, input logic [T-1:0] val);
      pk_seq = seq;
      pk_gbg = gbg;
      pk_hold = rnd ? T'($urandom) : val;
      for (int k = 0; k < N; k++) pk_q[k] = rnd ? T'($urandom) : val;
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pk_pf[r][c] = rnd ? T'($urandom) : val;
   endtask

   task automatic put(input logic [7:0] val, input int w);
      for (int b = w - 1; b >= 0; b--) begin
         pkt[pos] = val[b];
         pos--;
      end
   endtask

   task automatic send_data(input string tag, input logic ga, input int corrupt_lane, input int corrupt_bit,
                            input bit bad_start, input bit with_hs, input logic hs_seq,
                            input logic [1:0] hs_pid, input bit b2b);
      logic [L-1:0] lv [4];
      logic [3:0]   par;
      logic [6:0]   hw;
      logic [3:0]   ln;
      bit           ok;
      pkt = '0;
      pos = 4 * L - 1;
      put(8'(pk_seq), 1);
      put(8'(pk_gbg), G);
      put(8'(pk_hold), T);
      for (int k = 0; k < N; k++) put(8'(pk_q[k]), T);
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) put(8'(pk_pf[r][c]), T);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < L; j++) lv[i][L-1-j] = pkt[4*L-1 - i*L - j];
         par[i] = ^lv[i];
      end
      if (corrupt_lane >= 0) lv[corrupt_lane][corrupt_bit] = ~lv[corrupt_lane][corrupt_bit];
      hw = {1'b1, hs_seq, ~hs_seq, hs_pid, ~hs_pid};
      for (int k = 0; k < L + 2; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (pending) begin
               check_state({tag, "_prev"});
               pending = 0;
            end
            game_active = ga;
         end
         for (int i = 0; i < 4; i++) begin
            if (k == 0) ln[i] = !(bad_start && i == 1);
            else if (k <= L) ln[i] = lv[i][L-k];
            else ln[i] = par[i];
         end
         {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = ln;
         serial_in_h = (with_hs && k >= L - 5) ? hw[6 - (k - (L - 5))] : 1'b0;
      end
      clear_pulses();
      ok = (corrupt_lane < 0) && !bad_start;
      if (with_hs) hs_model(hs_seq, hs_pid);
      e_rd = ok;
      if (ok) m_pkt_cnt = (m_pkt_cnt + 1) % 16;
      if (ok && ga && pk_seq != m_last_seq) begin
         e_upd = 1;
         m_last_seq = pk_seq;
         m_gbg = pk_gbg;
         m_hold = pk_hold;
         for (int k = 0; k < N; k++) m_q[k] = pk_q[k];
         for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) m_pf[r][c] = pk_pf[r][c];
      end
      if (ok && ga) begin
         e_sra = 1;
         m_ack_out = pk_seq;
      end
      if (b2b) pending = 1;
      else begin
         @(negedge clk);
         {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = 4'b0;
         serial_in_h = 0;
         check_state(tag);
         @(negedge clk);
         check_pulses_low(tag);
      end
   endtask

   task automatic send_hs(input string tag, input logic seq, input logic [1:0] pid, input int bad);
      logic [6:0] w;
      w = {1'b1, seq, ~seq, pid, ~pid};
      if (bad == 1) w[4] = ~w[4];
      if (bad == 2) w[0] = ~w[0];
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         serial_in_h = w[6-k];
      end
      @(negedge clk);
      serial_in_h = 0;
      clear_pulses();
      if (bad == 0) hs_model(seq, pid);
      check_state(tag);
      @(negedge clk);
      check_pulses_low(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout reached before end of test");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; game_active = 0; serial_in_h = 0;
      {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = 4'b0;
      model_reset();
      @(negedge clk);
      check_state("reset");
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      check_state("after_reset");

      fill_pkt(1'b0, 4'd1, 0, 4'd1);
      send_data("seq0", 1, -1, 0, 0, 0, 0, 2'b00, 0);
      fill_pkt(1'b1, 4'd5, 0, 4'd2);
      send_data("seq1", 1, -1, 0, 0, 0, 0, 2'b00, 0);
      fill_pkt(1'b1, 4'd7, 0, 4'd3);
      send_data("dup_seq1", 1, -1, 0, 0, 0, 0, 2'b00, 0);
      fill_pkt(1'b0, 4'd9, 0, 4'd4);
      send_data("lane2_flip", 1, 2, 37, 0, 0, 0, 2'b00, 0);
      send_data("bad_start", 1, -1, 0, 1, 0, 0, 2'b00, 0);

      send_hs("hs_ready", 1'b0, 2'b01, 0);
      send_hs("hs_lost", 1'b0, 2'b10, 0);
      send_hs("hs_ack1", 1'b1, 2'b00, 0);
      send_hs("hs_bad_seqn", 1'b0, 2'b00, 1);
      send_hs("hs_bad_pidn", 1'b0, 2'b00, 2);
      send_hs("hs_reserved", 1'b1, 2'b11, 0);

      fill_pkt(1'b0, 4'd3, 1, 4'd0);
      send_data("inactive", 0, -1, 0, 0, 0, 0, 2'b00, 0);
      send_data("concurrent_ready", 1, -1, 0, 0, 1, 1'b1, 2'b01, 0);
      fill_pkt(1'b1, 4'd11, 1, 4'd0);
      send_data("concurrent_ack", 1, -1, 0, 0, 1, 1'b0, 2'b00, 0);
      send_hs("ready_alone", 1'b1, 2'b01, 0);

      fill_pkt(1'b0, 4'd2, 1, 4'd0);
      send_data("b2b_a", 1, -1, 0, 0, 0, 0, 2'b00, 1);
      fill_pkt(1'b1, 4'd6, 1, 4'd0);
      send_data("b2b_b", 1, -1, 0, 0, 0, 0, 2'b00, 0);

      for (int n = 0; n < 14; n++) begin
         int cl;
         fill_pkt(1'($urandom_range(0, 1)), G'($urandom), 1, 4'd0);
         cl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         send_data("rand", ($urandom_range(0, 3) != 0), cl, int'($urandom_range(0, L - 1)), 0,
                   bit'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   (n != 13) && ($urandom_range(0, 1) == 1));
      end

      for (int n = 0; n < 16; n++) send_hs("ack_wrap", 1'($urandom_range(0, 1)), 2'b00, 0);

      // Abort a data frame part-way with an asynchronous reset
      fill_pkt(1'b1, 4'd8, 1, 4'd0);
      send_data("pre_reset", 1, -1, 0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = 4'hF;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = 4'($urandom);
      end
      #2;
      rst = 1;
      #1;
      model_reset();
      check_state("mid_frame_reset");
      {serial_in_3, serial_in_2, serial_in_1, serial_in_0} = 4'b0;
      @(negedge clk);
      rst = 0;
      fill_pkt(1'b0, 4'd13, 1, 4'd0);
      send_data("fresh_after_reset", 1, -1, 0, 0, 0, 0, 2'b00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tetris_link_receiver.md
Name: tetris_link_receiver

Overview:
- Receive side of the two-player serial link.
- Deserialises 4 data lanes carrying the opponent's game-state packet and 1 handshake lane carrying ACK/READY/GAME_LOST packets.
- Validates frames, latches opponent state and raises pulses/flags for the local game FSM and the local sender.
- Sits between the GPIO pins and game logic; the peer sender drives all five lanes from the same clock.

Parameters:
- GBG_BITS, 4, garbage field width.
- TILE_BITS, 4, tile code width (0 = blank).
- NEXT_PIECES_COUNT, 6, queue entries.
- PLAYFIELD_ROWS, 20, playfield rows.
- PLAYFIELD_COLS, 10, playfield columns.

Ports:
- clk  in  1  single system clock; all lanes sampled on rising edge.
- rst  in  1  asynchronous, active-high reset.
- game_active  in  1  data packets accepted only when 1.
- serial_in_h  in  1  handshake lane, idle 0.
- serial_in_0..serial_in_3  in  1 each  data lanes, idle 0.
- send_ready_ACK  out  1  pulse: request local sender to emit ACK.
- ack_seqNum_out  out  1  seqNum the local sender must ACK.
- ack_received  out  1  pulse: valid ACK handshake received.
- ack_seqNum  out  1  seqNum carried by last valid ACK.
- update_opponent_data  out  1  pulse: opponent fields just updated.
- opponent_garbage  out  GBG_BITS.
- opponent_hold  out  TILE_BITS.
- opponent_piece_queue  out  NEXT_PIECES_COUNT x TILE_BITS.
- opponent_playfield  out  ROWS x COLS x TILE_BITS.
- opponent_ready  out  1  sticky: READY received.
- opponent_lost  out  1  sticky: GAME_LOST received.
- receive_done  out  1  pulse: valid data frame completed.
- receive_done_h  out  1  pulse: valid handshake frame completed.
- packets_received_cnt  out  4  valid data frames, wraps 15 -> 0.
- acks_received_cnt  out  4  valid ACKs, wraps 15 -> 0.

Behaviour:
- Data packet encoding:
  - P = 1 + GBG_BITS + TILE_BITS*(1 + NEXT_PIECES_COUNT + ROWS*COLS) bits, zero-padded at the LSB end to 4L bits (L = ceil(P/4)).
  - MSB to LSB order: seqNum, garbage, hold, queue[0..N-1], playfield[0][0], [0][1] ... [R-1][C-1].
  - Lane i carries bits [4L-1-i*L : 4L-(i+1)*L], MSB first.
  - With default parameters P = 833 and L = 209.
- Data frame, per lane: start bit 1, then L payload bits, then 1 even-parity bit over the payload.
- Framing:
  - Frame begins when serial_in_0 is 1 in IDLE.
  - Lanes 1-3 must also show 1 in that cycle; otherwise the whole frame is treated as erroneous, but the full frame length is still consumed.
- Data FSM states: IDLE -> SHIFT (L cycles) -> PARITY (1 cycle) -> IDLE.
- The cycle after the parity bit is sampled:
  - If all four parities pass and all start bits were good, pulse receive_done and increment packets_received_cnt.
  - If game_active=1 and seqNum differs from last accepted seqNum, latch the fields into the opponent_* outputs in that same cycle and pulse update_opponent_data.
  - If game_active=1, pulse send_ready_ACK with ack_seqNum_out = packet seqNum. This applies to duplicates too, so that lost ACKs are recovered.
  - Last accepted seqNum resets to 1, so the first packet (seqNum 0) is new.
  - game_active=0: frame counted and receive_done pulsed; no latch, no ACK.
- Bad frame: no pulses, no counter change, no output change.
- New start bit is accepted the cycle after PARITY, giving back-to-back frames with zero gap.
- Handshake frame on serial_in_h:
  - Start bit 1, then 6 bits {seqNum, seqNum_n, pid[1:0], pid_n[1:0]}.
  - Valid iff seqNum_n == ~seqNum and pid_n == ~pid.
  - Valid completion pulses receive_done_h the cycle after the last bit.
- pid 00 ACK:
  - Pulse ack_received.
  - Set ack_seqNum = seqNum (held).
  - Increment acks_received_cnt.
- pid 01 READY:
  - Set opponent_ready.
  - Pulse send_ready_ACK with ack_seqNum_out = seqNum.
- pid 10 GAME_LOST: set opponent_lost.
- pid 11: reserved; receive_done_h pulses, no other effect.
- Invalid handshake frame: silently dropped.
- Concurrency:
  - Handshake and data FSMs are independent; both may complete in the same cycle.
  - If both request send_ready_ACK in the same cycle, the data ACK wins and the READY response is dropped.
- Reset, asynchronous, any time including mid-frame:
  - FSMs go to IDLE.
  - All pulses 0, counters 0, flags 0.
  - Opponent garbage, hold, queue and playfield go to 0.
  - ack_seqNum and ack_seqNum_out go to 0.
- Pulse outputs are exactly 1 cycle wide and registered.

Test Plan:
- Reset, game_active=1, peer sends data seqNum 0, garbage 1, all tiles code 1 -> after L+2 cycles receive_done=1 for 1 cycle; opponent_garbage=1; every hold/queue/playfield entry =1; packets_received_cnt=1; send_ready_ACK pulse with ack_seqNum_out=0.
- Follow with seqNum 1, garbage 5, all tiles code 2 -> outputs update to 5/2; count=2; ACK seqNum 1.
- Resend seqNum 1 with garbage 7 -> receive_done and ACK pulse occur; opponent_garbage stays 5; update_opponent_data stays 0.
- Flip one payload bit on lane 2 -> no receive_done; outputs and counters unchanged.
- Handshake READY {0,1,01,10} -> receive_done_h pulse; opponent_ready=1; send_ready_ACK pulse.
- Handshake GAME_LOST -> opponent_lost=1.
- Handshake ACK seq 1 -> ack_received pulse; ack_seqNum=1; acks_received_cnt=1.
- Bad complement bits -> no effect.
- Assert rst mid data frame, then send a fresh frame -> all outputs 0 immediately; the fresh frame is received correctly.
